udt_rx_hdr_parse: RTL

- Sits directly downstream of the UDP byte-order/keep translation stage. Consumes its 64-bit AXI-Stream.
- In that stream the first byte of each beat is in [63:56], and last-beat keep is MSB-contiguous (0x80..0xFF).
- Strips the 16-byte UDT header (two beats), presents decoded header fields as a one-cycle sideband pulse, and forwards the payload through a registered 2-entry skid buffer.

---
 rtl/udt_pkg.sv | 23 ++
 rtl/udt_skid_buf.sv | 77 +++++++
 rtl/udt_rx_hdr_parse.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/udt_pkg.sv
// Shared definitions for the UDT receive header parser: FSM state encoding,
// UDT header layout constants and a byte-enable popcount helper.
package udt_pkg;

  typedef enum logic [1:0] {
    S_HDR0 = 2'd0,
    S_HDR1 = 2'd1,
    S_PAY  = 2'd2,
    S_DROP = 2'd3
  } state_e;

  localparam int UDT_HDR_BYTES = 16;
  localparam int CTRL_BIT      = 31;
  localparam int SEQ_W         = 31;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/udt_skid_buf.sv
// Two-entry AXI-Stream register slice carrying data, keep, last and the
// running byte length. Outputs come straight from the head register.
module udt_skid_buf #(
  parameter int LEN_W = 16
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             in_push,
  input  logic [63:0]      in_data,
  input  logic [7:0]       in_keep,
  input  logic             in_last,
  input  logic [LEN_W-1:0] in_len,
  output logic             full_next,
  output logic [63:0]      out_tdata,
  output logic [7:0]       out_tkeep,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             out_tlast,
  output logic [LEN_W-1:0] out_len
);

  localparam int ENT_W = 64 + 8 + 1 + LEN_W;

  logic [ENT_W-1:0] head_q, head_d, tail_q, tail_d, in_ent;
  logic             head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
  logic             pop;

  assign in_ent = {in_data, in_keep, in_last, in_len};
  assign pop    = head_vld_q & out_tready;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (pop) begin
      if (tail_vld_q) begin
        head_d     = tail_q;
        tail_vld_d = in_push;
        if (in_push) tail_d = in_ent;
      end else begin
        head_vld_d = in_push;
        if (in_push) head_d = in_ent;
      end
    end else if (in_push) begin
      if (!head_vld_q) begin
        head_vld_d = 1'b1;
        head_d     = in_ent;
      end else begin
        tail_vld_d = 1'b1;
        tail_d     = in_ent;
      end
    end
  end

  // NOTE: the two data registers are reset as well so out_tdata/out_tkeep read 0 out of reset.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

  // Full next cycle means the tail entry will be occupied.
  assign full_next = tail_vld_d;
  assign {out_tdata, out_tkeep, out_tlast, out_len} = head_q;
  assign out_tvalid = head_vld_q;

endmodule

// File: rtl/udt_rx_hdr_parse.sv
// UDT receive header parser: strips the 16-byte header, pulses decoded fields,
// forwards payload through a 2-entry skid. Optional macro: UDT_RX_CTRL_DROP_EN.
module udt_rx_hdr_parse
  import udt_pkg::*;
#(
  parameter int MAX_BEATS = 1024,
  parameter int LEN_W     = 16
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic [63:0]      in_tdata,
  input  logic [7:0]       in_tkeep,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic             in_tlast,
  output logic [63:0]      out_tdata,
  output logic [7:0]       out_tkeep,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             out_tlast,
  output logic [LEN_W-1:0] out_len,
  output logic             hdr_valid,
  output logic             hdr_ctrl,
  output logic [SEQ_W-1:0] hdr_seq,
  output logic [31:0]      hdr_msg,
  output logic [31:0]      hdr_tstamp,
  output logic [31:0]      hdr_sockid,
  output logic             err_runt,
  output logic             err_long
);

  localparam int               BEAT_W   = $clog2(MAX_BEATS + 2);
  localparam logic [BEAT_W-1:0] BEAT_LIM = BEAT_W'(MAX_BEATS);
  localparam logic [LEN_W-1:0]  LEN_MAX  = '1;

  state_e            state_q, state_d;
  logic              accept, push, ctrl_pkt, skid_full_next, ready_d;
  logic [31:0]       word0_q, word1_q;
  logic [LEN_W-1:0]  byte_cnt_q, len_sum;
  logic [LEN_W:0]    len_wide;
  logic [BEAT_W-1:0] beat_cnt_q;

  assign accept   = in_tvalid & in_tready;
  assign len_wide = {1'b0, byte_cnt_q} + (LEN_W + 1)'(popcount8(in_tkeep));
  assign len_sum  = len_wide[LEN_W] ? LEN_MAX : len_wide[LEN_W-1:0];

`ifdef UDT_RX_CTRL_DROP_EN
  assign ctrl_pkt = word0_q[CTRL_BIT];
`else
  assign ctrl_pkt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      S_HDR0: if (accept && !in_tlast) state_d = S_HDR1;
      S_HDR1: if (accept) state_d = in_tlast ? S_HDR0 : (ctrl_pkt ? S_DROP : S_PAY);
      S_PAY: begin
        push = accept;
        if (accept && in_tlast) state_d = S_HDR0;
      end
      S_DROP: if (accept && in_tlast) state_d = S_HDR0;
      default: state_d = S_HDR0;
    endcase
  end

  // Ready is registered from next-cycle occupancy, so out_tready never reaches in_tready combinationally.
  assign ready_d = (state_d == S_PAY) ? !skid_full_next : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q   <= S_HDR0;
      in_tready <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_tready <= ready_d;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      word0_q    <= '0;
      word1_q    <= '0;
      byte_cnt_q <= '0;
      beat_cnt_q <= '0;
      hdr_valid  <= 1'b0;
      hdr_ctrl   <= 1'b0;
      hdr_seq    <= '0;
      hdr_msg    <= '0;
      hdr_tstamp <= '0;
      hdr_sockid <= '0;
      err_runt   <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      err_runt  <= 1'b0;
      err_long  <= 1'b0;
      if (accept) begin
        case (state_q)
          S_HDR0: begin
            word0_q  <= in_tdata[63:32];
            word1_q  <= in_tdata[31:0];
            err_runt <= in_tlast;
          end
          S_HDR1: begin
            hdr_valid  <= 1'b1;
            hdr_ctrl   <= word0_q[CTRL_BIT];
            hdr_seq    <= word0_q[SEQ_W-1:0];
            hdr_msg    <= word1_q;
            hdr_tstamp <= in_tdata[63:32];
            hdr_sockid <= in_tdata[31:0];
            byte_cnt_q <= '0;
            beat_cnt_q <= '0;
          end
          S_PAY: begin
            byte_cnt_q <= len_sum;
            // Beat count saturates one past the limit; enough to flag the overrun.
            if (beat_cnt_q <= BEAT_LIM) beat_cnt_q <= beat_cnt_q + 1'b1;
            err_long <= in_tlast && (beat_cnt_q >= BEAT_LIM);
          end
          default: ;
        endcase
      end
    end
  end

  udt_skid_buf #(.LEN_W(LEN_W)) u_skid (
    .core_clk   (core_clk),
    .core_rst   (core_rst),
    .in_push    (push),
    .in_data    (in_tdata),
    .in_keep    (in_tkeep),
    .in_last    (in_tlast),
    .in_len     (len_sum),
    .full_next  (skid_full_next),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast),
    .out_len    (out_len)
  );

endmodule
